// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: defaults, control-bundle layout,
// and the writeback bypass match rule.
package id_ex_pipe_stage_pkg;

  localparam int unsigned XlenDef  = 32;
  localparam int unsigned AwDef    = 5;
  localparam int unsigned CtrlWDef = 16;
  localparam int unsigned NumWbDef = 1;
  localparam int unsigned MaxAw    = 16;

  localparam logic [CtrlWDef-1:0] CtrlRstDef = '0;

  // Control bundle layout; opaque to this stage, decoded by EX.
  localparam int unsigned CtrlAluOpLsb  = 0;
  localparam int unsigned CtrlAluOpW    = 4;
  localparam int unsigned CtrlJumpBit   = 4;
  localparam int unsigned CtrlBranchBit = 5;
  localparam int unsigned CtrlLoadBit   = 6;
  localparam int unsigned CtrlStoreBit  = 7;
  localparam int unsigned CtrlWbEnBit   = 8;
  localparam int unsigned CtrlCsrWeBit  = 9;

  // x0 is hardwired, so a write to it must never be forwarded.
  function automatic logic wb_match(input logic             we,
                                    input logic [MaxAw-1:0] wb_addr,
                                    input logic [MaxAw-1:0] src_addr);
    return we && (src_addr != '0) && (wb_addr == src_addr);
  endfunction

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX stage.
interface id_ex_pipe_stage_if
  import id_ex_pipe_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDef,
  parameter int unsigned AW     = AwDef,
  parameter int unsigned CTRL_W = CtrlWDef
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_pc_plus;
  logic [AW-1:0]     in_rs1_addr;
  logic [AW-1:0]     in_rs2_addr;
  logic [AW-1:0]     in_rd_addr;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_pc_plus;
  logic [AW-1:0]     out_rs1_addr;
  logic [AW-1:0]     out_rs2_addr;
  logic [AW-1:0]     out_rd_addr;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_pc, in_pc_plus, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_rs1_data, in_rs2_data, in_imm, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rs1_data, out_rs2_data, out_imm, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_pc_plus, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_rs1_data, in_rs2_data, in_imm, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rs1_data, out_rs2_data, out_imm, out_ctrl
  );

endinterface

// File: rtl/id_ex_bypass.sv
// Combinational writeback bypass for one source operand across NUM_WB ports.
module id_ex_bypass
  import id_ex_pipe_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDef,
  parameter int unsigned AW     = AwDef,
  parameter int unsigned NUM_WB = NumWbDef
) (
  input  logic [AW-1:0]          src_addr,
  input  logic [XLEN-1:0]        src_data,
  input  logic [NUM_WB-1:0]      wb_we,
  input  logic [NUM_WB*AW-1:0]   wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  output logic [XLEN-1:0]        res_data
);

  // Scan from the highest port down so port 0 (youngest) has the final say.
  always_comb begin
    res_data = src_data;
    for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
      if (wb_match(wb_we[p], MaxAw'(wb_addr[p*AW +: AW]), MaxAw'(src_addr))) begin
        res_data = wb_data[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage with 2-entry skid buffer, flush and writeback bypass/refresh.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_stage
  import id_ex_pipe_stage_pkg::*;
#(
  parameter int unsigned       XLEN     = XlenDef,
  parameter int unsigned       AW       = AwDef,
  parameter int unsigned       CTRL_W   = CtrlWDef,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CtrlRstDef),
  parameter int unsigned       NUM_WB   = NumWbDef
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_WB-1:0]      wb_we,
  input  logic [NUM_WB*AW-1:0]   wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  id_ex_pipe_stage_if.slave      io
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_bubble_cnt
`endif
);

  // Static payload packing, LSB first: ctrl, imm, rd, rs2, rs1, pc_plus, pc.
  localparam int unsigned SW     = 3 * XLEN + 3 * AW + CTRL_W;
  localparam int unsigned Rs2Lsb = CTRL_W + XLEN + AW;
  localparam int unsigned Rs1Lsb = Rs2Lsb + AW;

  logic            r_main_valid, w_main_valid_nxt;
  logic            r_skid_valid, w_skid_valid_nxt;
  logic [SW-1:0]   r_main_sta, w_main_sta_nxt;
  logic [SW-1:0]   r_skid_sta, w_skid_sta_nxt;
  logic [SW-1:0]   w_in_sta;
  logic [XLEN-1:0] r_main_rs1, r_main_rs2, w_main_rs1_nxt, w_main_rs2_nxt;
  logic [XLEN-1:0] r_skid_rs1, r_skid_rs2, w_skid_rs1_nxt, w_skid_rs2_nxt;
  logic [XLEN-1:0] w_in_rs1_byp, w_in_rs2_byp;
  logic [XLEN-1:0] w_main_rs1_byp, w_main_rs2_byp;
  logic [XLEN-1:0] w_skid_rs1_byp, w_skid_rs2_byp;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic            w_accept, w_main_free;

  assign w_in_sta = {io.in_pc, io.in_pc_plus, io.in_rs1_addr, io.in_rs2_addr, io.in_rd_addr,
                     io.in_imm, io.in_ctrl};
  assign {io.out_pc, io.out_pc_plus, io.out_rs1_addr, io.out_rs2_addr, io.out_rd_addr,
          io.out_imm, w_main_ctrl} = r_main_sta;

  assign io.in_ready     = ~r_skid_valid;
  assign io.out_valid    = r_main_valid;
  assign io.out_rs1_data = r_main_rs1;
  assign io.out_rs2_data = r_main_rs2;
  assign io.out_ctrl     = r_main_valid ? w_main_ctrl : CTRL_RST;

  assign w_accept    = io.in_valid & ~r_skid_valid;
  assign w_main_free = ~r_main_valid | io.out_ready;

  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_in_rs1 (
    .src_addr(io.in_rs1_addr), .src_data(io.in_rs1_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_in_rs1_byp)
  );
  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_in_rs2 (
    .src_addr(io.in_rs2_addr), .src_data(io.in_rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_in_rs2_byp)
  );
  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_main_rs1 (
    .src_addr(r_main_sta[Rs1Lsb +: AW]), .src_data(r_main_rs1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_main_rs1_byp)
  );
  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_main_rs2 (
    .src_addr(r_main_sta[Rs2Lsb +: AW]), .src_data(r_main_rs2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_main_rs2_byp)
  );
  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_skid_rs1 (
    .src_addr(r_skid_sta[Rs1Lsb +: AW]), .src_data(r_skid_rs1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_skid_rs1_byp)
  );
  id_ex_bypass #(.XLEN(XLEN), .AW(AW), .NUM_WB(NUM_WB)) u_byp_skid_rs2 (
    .src_addr(r_skid_sta[Rs2Lsb +: AW]), .src_data(r_skid_rs2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .res_data(w_skid_rs2_byp)
  );

  // Held entries absorb this cycle's writebacks; a skid entry moving to main keeps them too.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_sta_nxt   = r_main_sta;
    w_main_rs1_nxt   = w_main_rs1_byp;
    w_main_rs2_nxt   = w_main_rs2_byp;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_sta_nxt   = r_skid_sta;
    w_skid_rs1_nxt   = w_skid_rs1_byp;
    w_skid_rs2_nxt   = w_skid_rs2_byp;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_valid_nxt = 1'b1;
        w_main_sta_nxt   = r_skid_sta;
        w_main_rs1_nxt   = w_skid_rs1_byp;
        w_main_rs2_nxt   = w_skid_rs2_byp;
        w_skid_valid_nxt = w_accept;
        w_skid_sta_nxt   = w_in_sta;
        w_skid_rs1_nxt   = w_in_rs1_byp;
        w_skid_rs2_nxt   = w_in_rs2_byp;
      end else begin
        w_main_valid_nxt = w_accept;
        if (w_accept) begin
          w_main_sta_nxt = w_in_sta;
          w_main_rs1_nxt = w_in_rs1_byp;
          w_main_rs2_nxt = w_in_rs2_byp;
        end
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_sta_nxt   = w_in_sta;
      w_skid_rs1_nxt   = w_in_rs1_byp;
      w_skid_rs2_nxt   = w_in_rs2_byp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_sta   <= '0;
      r_skid_sta   <= '0;
      r_main_rs1   <= '0;
      r_main_rs2   <= '0;
      r_skid_rs1   <= '0;
      r_skid_rs2   <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_main_sta   <= w_main_sta_nxt;
      r_skid_sta   <= w_skid_sta_nxt;
      r_main_rs1   <= w_main_rs1_nxt;
      r_main_rs2   <= w_main_rs2_nxt;
      r_skid_rs1   <= w_skid_rs1_nxt;
      r_skid_rs2   <= w_skid_rs2_nxt;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_valid && !io.out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!r_main_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: directed stimulus, expected entries queued in order.
module tb_id_ex_pipe_stage;

  localparam logic [15:0] CtrlRst = 16'h0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  wb_we;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  id_ex_pipe_stage_if #(.XLEN(32), .AW(5), .CTRL_W(16)) bus ();

  id_ex_pipe_stage #(
    .XLEN(32), .AW(5), .CTRL_W(16), .CTRL_RST(CtrlRst), .NUM_WB(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .io(bus)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [15:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [4:0] rd,
                       input logic [15:0] ctrl);
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_pc_plus  = pc + 32'd4;
    bus.in_rs1_addr = rs1a;
    bus.in_rs1_data = rs1d;
    bus.in_rs2_addr = rs2a;
    bus.in_rs2_data = rs2d;
    bus.in_rd_addr  = rd;
    bus.in_imm      = pc ^ 32'h5A5A_0000;
    bus.in_ctrl     = ctrl;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [15:0] ctrl);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ctrl = ctrl;
    q.push_back(e);
  endtask

  task automatic set_wb(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wb_we   = we;
    wb_addr = {a1, a0};
    wb_data = {d1, d0};
  endtask

  // Monitor: every consumed entry must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc 0x%0h, expected no output", bus.out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", bus.out_pc, e.pc);
        chk("sb_pc_plus", bus.out_pc_plus, e.pc + 32'd4);
        chk("sb_imm", bus.out_imm, e.pc ^ 32'h5A5A_0000);
        chk("sb_rd", 32'(bus.out_rd_addr), 32'(e.rd));
        chk("sb_rs1_data", bus.out_rs1_data, e.rs1);
        chk("sb_rs2_data", bus.out_rs2_data, e.rs2);
        chk("sb_ctrl", 32'(bus.out_ctrl), 32'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] b0, s0;
`endif
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    drive(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 16'h0);
    bus.in_valid = 1'b0;
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick(); tick();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_ctrl", 32'(bus.out_ctrl), 32'(CtrlRst));
    rst = 1'b0;
    tick();

    // Single instruction, one-cycle latency.
    bus.out_ready = 1'b1;
    drive(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 16'h00A1);
    push_exp(32'h100, 5'd3, 32'h11, 32'h22, 16'h00A1);
    tick();
    bus.in_valid = 1'b0;
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_pc", bus.out_pc, 32'h100);
    chk("lat_out_pc_plus", bus.out_pc_plus, 32'h104);
    tick();
    chk("bubble_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bubble_out_ctrl", 32'(bus.out_ctrl), 32'(CtrlRst));

    // Stall with skid: A in main, B in skid, C refused until space frees.
    bus.out_ready = 1'b0;
    drive(32'h200, 5'd0, 32'h21, 5'd0, 32'h22, 5'd4, 16'h00B1);
    push_exp(32'h200, 5'd4, 32'h21, 32'h22, 16'h00B1);
    tick();
    drive(32'h300, 5'd0, 32'h31, 5'd0, 32'h32, 5'd5, 16'h00B2);
    push_exp(32'h300, 5'd5, 32'h31, 32'h32, 16'h00B2);
    tick();
    chk("skid_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(32'h400, 5'd0, 32'h41, 5'd0, 32'h42, 5'd6, 16'h00B3);
    push_exp(32'h400, 5'd6, 32'h41, 32'h42, 16'h00B3);
    tick(); tick();
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_pc", bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20; n++) begin
      acc = bus.in_ready;
      tick();
      if (acc) break;
    end
    chk("c_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    tick(); tick();

    // Input bypass: hit, x0, two-port priority, port 1 alone.
    drive(32'h600, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd1, 16'h0002);
    set_wb(2'b01, 5'd5, 32'hDEAD, 5'd0, 32'h0);
    push_exp(32'h600, 5'd1, 32'hDEAD, 32'h0, 16'h0002);
    tick();
    drive(32'h604, 5'd0, 32'h777, 5'd0, 32'h0, 5'd2, 16'h0003);
    set_wb(2'b01, 5'd0, 32'hBEEF, 5'd0, 32'h0);
    push_exp(32'h604, 5'd2, 32'h777, 32'h0, 16'h0003);
    tick();
    drive(32'h608, 5'd3, 32'h9, 5'd4, 32'h40, 5'd3, 16'h0004);
    set_wb(2'b11, 5'd3, 32'h1, 5'd3, 32'h2);
    push_exp(32'h608, 5'd3, 32'h1, 32'h40, 16'h0004);
    tick();
    drive(32'h60C, 5'd0, 32'h0, 5'd4, 32'h40, 5'd4, 16'h0005);
    set_wb(2'b10, 5'd0, 32'h0, 5'd4, 32'h44);
    push_exp(32'h60C, 5'd4, 32'h0, 32'h44, 16'h0005);
    tick();
    bus.in_valid = 1'b0;
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();

    // Refresh of held entries: x7 updates main, x9 updates skid.
    bus.out_ready = 1'b0;
    drive(32'h700, 5'd0, 32'h70, 5'd7, 32'h0, 5'd7, 16'h0006);
    push_exp(32'h700, 5'd7, 32'h70, 32'h55, 16'h0006);
    tick();
    drive(32'h704, 5'd9, 32'h90, 5'd0, 32'h0, 5'd8, 16'h0007);
    push_exp(32'h704, 5'd8, 32'h99, 32'h0, 16'h0007);
    tick();
    bus.in_valid = 1'b0;
    tick();
    set_wb(2'b11, 5'd7, 32'h55, 5'd9, 32'h99);
    tick();
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("refresh_rs2_data", bus.out_rs2_data, 32'h55);
    tick();
    chk("refresh_rs2_hold", bus.out_rs2_data, 32'h55);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();

    // Flush with both entries full and a new input presented.
    bus.out_ready = 1'b0;
    drive(32'h800, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 16'h00C1);
    tick();
    drive(32'h804, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 16'h00C2);
    tick();
    chk("pre_flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("pre_flush_out_valid", 32'(bus.out_valid), 32'd1);
    drive(32'h808, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 16'h00C3);
`ifdef ID_EX_PERF_CNT_EN
    s0 = perf_stall_cnt;
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_ctrl", 32'(bus.out_ctrl), 32'(CtrlRst));
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_inc", perf_stall_cnt, s0 + 32'd1);
    b0 = perf_bubble_cnt;
    tick();
    chk("perf_bubble_inc", perf_bubble_cnt, b0 + 32'd1);
`endif
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage, successor to the fixed register bank between decode and execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so throughput is full and in_ready comes from a register.
- Adds flush (bubble insertion), x0-aware writeback bypass from NUM_WB write ports, and refresh of stalled entries by later writebacks.
- Sits between the decoder/regfile read and the EX stage; the EX forwarding unit consumes its outputs.

Parameters:
XLEN, 32, width of data, PC and immediate.
AW, 5, register address width.
CTRL_W, 16, width of the opaque decoded control bundle (alu_op, jump, load, wb_en, csr_we, ...).
CTRL_RST, 0, reset and bubble value of out_ctrl.
NUM_WB, 1, number of writeback bypass ports, 1..4.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  kill all held entries and any input accepted this cycle
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept; equals NOT skid_valid (registered)
in_pc, in_pc_plus  in  XLEN  PC and PC+4
in_rs1_addr, in_rs2_addr, in_rd_addr  in  AW  source and destination register indices
in_rs1_data, in_rs2_data  in  XLEN  regfile read data
in_imm  in  XLEN  decoded immediate
in_ctrl  in  CTRL_W  control bundle
wb_we  in  NUM_WB  per-port writeback enable
wb_addr  in  NUM_WB*AW  packed writeback addresses, port 0 in LSBs
wb_data  in  NUM_WB*XLEN  packed writeback data
out_valid  out  1  main entry valid
out_ready  in  1  EX consumes the main entry
out_pc, out_pc_plus, out_rs1_addr, out_rs2_addr, out_rd_addr, out_rs1_data, out_rs2_data, out_imm, out_ctrl  out  as inputs  main-entry fields

Behaviour:
- Storage: main entry (drives outputs) and skid entry. Each entry holds all payload fields plus a valid bit.
- Reset: both valids=0, all payload=0, out_ctrl=CTRL_RST, in_ready=1. All values hold while rst is high. Reset mid-stall discards both entries.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready. Latency from accept to out_valid is 1 cycle when main is empty or being consumed.
- Next-state rules, evaluated per cycle:
  - main empty or consumed, skid valid → main<=skid, skid invalid; a same-cycle accept loads skid.
  - main empty or consumed, skid empty → main<=input if accept, else main invalid.
  - main held (valid, not consumed) and accept → skid<=input; in_ready drops next cycle.
- Skid full → in_ready=0; input is ignored even if in_valid=1.
- Bubble: when main is invalid, out_ctrl=CTRL_RST. Other payload fields hold their last value; the verifier checks them only when out_valid=1.
- Flush has priority over everything: next cycle main and skid are invalid, out_ctrl=CTRL_RST, and a same-cycle accept is discarded. in_ready is 1 in the cycle after a flush.
- Bypass on input: rsN_data captured = wb_data[p] if wb_we[p] & wb_addr[p]==in_rsN_addr & in_rsN_addr!=0, else in_rsN_data.
- Multiple matching ports: the lowest port index wins (port 0 is youngest).
- Bypass on hold: every cycle, each valid entry that is not being moved applies the same match/overwrite to its own rsN_data.
- The stored data reflects all writebacks up to the previous edge. Writebacks in the cycle of consumption are the EX forwarding unit's responsibility.
- Address 0 is never bypassed; rsN_data for x0 keeps the regfile value.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt (32) and perf_bubble_cnt (32), both reset to 0.
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_bubble_cnt increments each cycle with !out_valid.
  - Both counters wrap at 2^32 and are not cleared by flush.
- Undefined: no counters and no extra ports.

Decomposition:
- Shared package: ctrl-bundle field offsets/widths, XLEN/AW defaults, CTRL_RST encoding, and the bypass match function (addr!=0 & we & addr==src, lowest-index priority).
- One sub-module: id_ex_bypass, combinational. Given one register address and data plus the packed WB ports, it returns the resolved data. It is instantiated 6 times: input and each of the two entries, for rs1 and rs2.

Test Plan:
- Reset → out_valid=0, in_ready=1, out_ctrl=CTRL_RST. Feed pc=0x100 with out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_pc_plus=0x104.
- out_ready=0, push A then B → A on outputs, B in skid, in_ready=0. C is presented but not accepted. Raise out_ready → A, then B, then C once in_ready returns; no loss, no duplication.
- Input rs1_addr=5 with wb_we=1, wb_addr=5, wb_data=0xDEAD → out_rs1_data=0xDEAD. Repeat with addr 0 → regfile value kept.
- Stall A (rs2=7) for 3 cycles and write x7=0x55 during the stall → out_rs2_data becomes 0x55 the next cycle.
- NUM_WB=2, both ports write x3 (port0=0x1, port1=0x2) → captured value 0x1.
- Main and skid full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, out_ctrl=CTRL_RST. Under ID_EX_PERF_CNT_EN, perf_bubble_cnt increments from that cycle.
